// File: rtl/alu_pkg.sv
// Shared ALU op codes, legality check and arbiter FSM encoding.
// Optional round-robin arbitration is enabled with ALU_ARB_RR_EN.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_e;

  // Registered response payload; the tag is kept separately because its width is a parameter.
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        port;
  } arb_rsp_t;

  function automatic logic alu_op_legal(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL,
      ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU; unknown op codes produce a zero result.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'd0;
    case (alu_ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      default:  result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_arb_grant.sv
// Two-port grant generator. With ALU_ARB_RR_EN it holds a last-grant register
// for round-robin; otherwise port 0 has fixed priority and no state is built.
module alu_arb_grant (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic grant_o,
  output logic any_valid_o
);

  assign any_valid_o = valid0_i | valid1_i;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // Reset to 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o;
    end
  end

  assign grant_o = (valid0_i & valid1_i) ? ~last_q : valid1_i;
`else
  logic unused_grant_inputs;

  assign unused_grant_inputs = ^{clk, rst_n, accept_i};
  assign grant_o             = ~valid0_i & valid1_i;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready request ports and returns a registered,
// tagged response. ALU_ARB_RR_EN selects round-robin instead of port-0 priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_ctrl,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_port,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output arb_state_e       dbg_state
);

  // Handshake: a request transfers on an edge where reqN_valid & reqN_ready;
  // the response transfers on an edge where rsp_valid & rsp_ready, and rsp_*
  // hold stable while rsp_valid & !rsp_ready.

  arb_state_e       state_q;
  arb_rsp_t         rsp_q;
  arb_rsp_t         rsp_d;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_d;

  logic        can_accept;
  logic        accept;
  logic        grant;
  logic        any_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  assign rsp_valid  = (state_q == ARB_RESP);
  assign can_accept = (state_q == ARB_IDLE) | (rsp_valid & rsp_ready);
  assign accept     = can_accept & any_valid;

  assign req0_ready = can_accept & req0_valid & ~grant;
  assign req1_ready = can_accept & req1_valid & grant;

  alu_arb_grant u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .accept_i    (accept),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  assign alu_a    = grant ? req1_a    : req0_a;
  assign alu_b    = grant ? req1_b    : req0_b;
  assign alu_ctrl = grant ? req1_ctrl : req0_ctrl;

  alu u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  always_comb begin
    rsp_d.result  = alu_result;
    rsp_d.zero    = alu_zero;
    rsp_d.illegal = ~alu_op_legal(alu_ctrl);
    rsp_d.port    = grant;
    tag_d         = grant ? req1_tag : req0_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rsp_q   <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            rsp_q   <= rsp_d;
            tag_q   <= tag_d;
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // Consuming and accepting in the same cycle replaces the response in place.
          if (accept) begin
            rsp_q   <= rsp_d;
            tag_q   <= tag_d;
          end else if (rsp_ready) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rsp_port    = rsp_q.port;
  assign rsp_tag     = tag_q;
  assign rsp_result  = rsp_q.result;
  assign rsp_zero    = rsp_q.zero;
  assign rsp_illegal = rsp_q.illegal;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with hand-written multi-cycle sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_ctrl, req1_ctrl;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready, rsp_port, rsp_zero, rsp_illegal;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_result;
  arb_state_e       dbg_state;

  int errors = 0;
  int checks = 0;

  logic [TAG_W+31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req0_tag    (req0_tag),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .req1_tag    (req1_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_port    (rsp_port),
    .rsp_tag     (rsp_tag),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic set_p0(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic set_p1(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  task automatic check_rsp(input string n, input logic port, input logic [31:0] res,
                           input logic zero, input logic ill, input logic [TAG_W-1:0] tag);
    check({n, ".valid"},   32'(rsp_valid),   32'd1);
    check({n, ".port"},    32'(rsp_port),    32'(port));
    check({n, ".result"},  rsp_result,       res);
    check({n, ".zero"},    32'(rsp_zero),    32'(zero));
    check({n, ".illegal"}, 32'(rsp_illegal), 32'(ill));
    check({n, ".tag"},     32'(rsp_tag),     32'(tag));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.valid",   32'(rsp_valid),   32'd0);
    check("rst.result",  rsp_result,       32'd0);
    check("rst.zero",    32'(rsp_zero),    32'd0);
    check("rst.illegal", 32'(rsp_illegal), 32'd0);
    check("rst.port",    32'(rsp_port),    32'd0);
    check("rst.tag",     32'(rsp_tag),     32'd0);
    check("rst.state",   32'(dbg_state),   32'(ARB_IDLE));
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"add",      ALU_ADD,  32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1]  = '{"add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
    vecs[2]  = '{"and",      ALU_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 1'b0};
    vecs[3]  = '{"or",       ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0};
    vecs[4]  = '{"sub_neg",  ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5]  = '{"sub_zero", ALU_SUB,  32'd9,         32'd9,         32'd0,         1'b1, 1'b0};
    vecs[6]  = '{"xor",      ALU_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0};
    vecs[7]  = '{"sll31",    ALU_SLL,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 1'b0};
    vecs[8]  = '{"sll_mask", ALU_SLL,  32'd1,         32'h21,        32'd2,         1'b0, 1'b0};
    vecs[9]  = '{"srl",      ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0};
    vecs[10] = '{"sra",      ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0};
    vecs[11] = '{"slt",      ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
    vecs[12] = '{"sltu",     ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
    vecs[13] = '{"ill_1111", 4'b1111,  32'd5,         32'd7,         32'd0,         1'b1, 1'b1};
    vecs[14] = '{"ill_1001", 4'b1001,  32'hFFFF_FFFF, 32'd3,         32'd0,         1'b1, 1'b1};

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    set_p1(1'b0, 4'd0, 32'd0, 32'd0, '0);
    do_reset();

    // Single add
    @(negedge clk);
    set_p0(1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3);
    rsp_ready = 1'b1;
    #1;
    check("add1.req0_ready", 32'(req0_ready), 32'd1);
    check("add1.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    check_rsp("add1", 1'b0, 32'd12, 1'b0, 1'b0, 4'd3);

    // Op table on port 0
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_p0(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, 4'(i));
      #1;
      check({vecs[i].name, ".ready"}, 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
      check_rsp(vecs[i].name, 1'b0, vecs[i].res, vecs[i].zero, vecs[i].ill, 4'(i));
    end
    @(posedge clk); #1;
    check("drain.valid", 32'(rsp_valid), 32'd0);

    // Contention
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_p0(1'b1, ALU_SUB, 32'd9, 32'd9, 4'd1);
    set_p1(1'b1, ALU_XOR, 32'hF0, 32'h0F, 4'd2);
    #1;
    check("cont1.req0_ready", 32'(req0_ready), 32'd1);
    check("cont1.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    check_rsp("cont1", 1'b0, 32'd0, 1'b1, 1'b0, 4'd1);
    @(negedge clk);
    #1;
`ifdef ALU_ARB_RR_EN
    check("cont2.req0_ready", 32'(req0_ready), 32'd0);
    check("cont2.req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    check_rsp("cont2", 1'b1, 32'hFF, 1'b0, 1'b0, 4'd2);
`else
    check("cont2.req0_ready", 32'(req0_ready), 32'd1);
    check("cont2.req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    check_rsp("cont2", 1'b0, 32'd0, 1'b1, 1'b0, 4'd1);
`endif
    @(negedge clk);
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    #1;
    check("cont3.req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    set_p1(1'b0, 4'd0, 32'd0, 32'd0, '0);
    check_rsp("cont3", 1'b1, 32'hFF, 1'b0, 1'b0, 4'd2);

    // Backpressure with SRA, queued p1 request
    @(negedge clk);
    set_p0(1'b1, ALU_SRA, 32'h8000_0000, 32'd4, 4'd5);
    #1;
    check("bp.req0_ready", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    set_p1(1'b1, ALU_ADD, 32'd2, 32'd3, 4'd9);
    check_rsp("bp.first", 1'b0, 32'hF800_0000, 1'b0, 1'b0, 4'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp.stall.req0_ready", 32'(req0_ready), 32'd0);
      check("bp.stall.req1_ready", 32'(req1_ready), 32'd0);
      check_rsp("bp.stall", 1'b0, 32'hF800_0000, 1'b0, 1'b0, 4'd5);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp.release.req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    set_p1(1'b0, 4'd0, 32'd0, 32'd0, '0);
    check_rsp("bp.queued", 1'b1, 32'd5, 1'b0, 1'b0, 4'd9);
    @(posedge clk); #1;
    check("bp.idle.valid", 32'(rsp_valid), 32'd0);

    // Reset mid-operation; last op on port 0 so only reset can restore port 0 priority
    @(negedge clk);
    rsp_ready = 1'b0;
    set_p0(1'b1, ALU_ADD, 32'd1, 32'd1, 4'd7);
    @(posedge clk); #1;
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    check_rsp("mid.pre", 1'b0, 32'd2, 1'b0, 1'b0, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.valid",  32'(rsp_valid),  32'd0);
    check("mid.result", rsp_result,      32'd0);
    check("mid.tag",    32'(rsp_tag),    32'd0);
    check("mid.state",  32'(dbg_state),  32'(ARB_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_p0(1'b1, ALU_OR, 32'h10, 32'h01, 4'd4);
    set_p1(1'b1, ALU_AND, 32'hFF, 32'h0F, 4'd6);
    #1;
    check("mid.state_idle",  32'(dbg_state),  32'(ARB_IDLE));
    check("mid.req0_ready",  32'(req0_ready), 32'd1);
    check("mid.req1_ready",  32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    set_p0(1'b0, 4'd0, 32'd0, 32'd0, '0);
    set_p1(1'b0, 4'd0, 32'd0, 32'd0, '0);
    check_rsp("mid.post", 1'b0, 32'h11, 1'b0, 1'b0, 4'd4);

    // Streaming: ten back-to-back port 1 requests, scoreboarded
    for (int i = 0; i < 10; i++) begin
      logic [TAG_W+31:0] exp;
      @(negedge clk);
      set_p1(1'b1, ALU_ADD, 32'(i * 3), 32'd100, 4'(i));
      exp_q.push_back({4'(i), 32'(i * 3 + 100)});
      #1;
      check("stream.req1_ready", 32'(req1_ready), 32'd1);
      @(posedge clk); #1;
      check("stream.valid", 32'(rsp_valid), 32'd1);
      check("stream.port",  32'(rsp_port),  32'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("stream.tag",    32'(rsp_tag), 32'(exp[TAG_W+31:32]));
        check("stream.result", rsp_result,   exp[31:0]);
      end else begin
        check("stream.queue_nonempty", 32'd0, 32'd1);
      end
    end
    set_p1(1'b0, 4'd0, 32'd0, 32'd0, '0);
    @(posedge clk); #1;
    check("stream.end.valid", 32'(rsp_valid), 32'd0);
    check("stream.queue_left", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
